// File: rtl/regfile_stack_ctrl_if.sv
// Request/status bundle between a core and the register-file stack controller.
// The controller takes the slave side; the requester takes the master side.
interface regfile_stack_ctrl_if #(
   parameter int LW = 2
) ();
   logic          i_push_req;
   logic          i_pop_req;
   logic          i_clear_err;
   logic          o_busy;
   logic          o_done;
   logic [LW-1:0] o_level;
   logic [LW-1:0] o_rd_level;
   logic [LW-1:0] o_wr_level;
   logic [4:0]    o_cp_addr;
   logic          o_cp_we;
   logic          o_overflow;
   logic          o_underflow;

   modport master (
      output i_push_req, i_pop_req, i_clear_err,
      input  o_busy, o_done, o_level, o_rd_level, o_wr_level,
      input  o_cp_addr, o_cp_we, o_overflow, o_underflow
   );

   modport slave (
      input  i_push_req, i_pop_req, i_clear_err,
      output o_busy, o_done, o_level, o_rd_level, o_wr_level,
      output o_cp_addr, o_cp_we, o_overflow, o_underflow
   );
endinterface

// File: rtl/regfile_stack_ctrl.sv
// Register-file stack level controller: push copies COPY_N registers into
// the new level one per cycle, pop just steps back; all outputs from state.
module regfile_stack_ctrl #(
   parameter int DEPTH     = 4,
   parameter int COPY_N    = 2,
   parameter int COPY_BASE = 10,
   parameter int LW        = $clog2(DEPTH)
) (
   input logic                 i_clk,
   input logic                 i_reset,
   regfile_stack_ctrl_if.slave bus
);
   localparam int KW = 4;
   localparam logic [KW-1:0] K_LAST = KW'((COPY_N == 0) ? 0 : COPY_N - 1);
   localparam logic [LW-1:0] TOP    = LW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] level_q, level_d;
   logic [KW-1:0] k_q, k_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         level_q <= '0;
         k_q     <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         k_q     <= k_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      k_d     = k_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      // Clear first so a flag set in the same cycle wins.
      if (bus.i_clear_err) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            if (bus.i_push_req) begin
               state_d = DONE;
               if (level_q == TOP) begin
                  ovf_d = 1'b1;
               end else if (COPY_N == 0) begin
                  level_d = level_q + LW'(1);
               end else begin
                  state_d = COPY;
                  k_d     = '0;
               end
            end else if (bus.i_pop_req) begin
               state_d = DONE;
               if (level_q == '0) begin
                  unf_d = 1'b1;
               end else begin
                  level_d = level_q - LW'(1);
               end
            end
         end
         COPY: begin
            if (k_q == K_LAST) begin
               level_d = level_q + LW'(1);
               k_d     = '0;
               state_d = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_busy      = (state_q != IDLE);
   assign bus.o_done      = (state_q == DONE);
   assign bus.o_level     = level_q;
   assign bus.o_rd_level  = level_q;
   assign bus.o_cp_we     = (state_q == COPY);
   assign bus.o_wr_level  = (state_q == COPY) ? level_q + LW'(1) : level_q;
   assign bus.o_cp_addr   = (state_q == COPY) ? 5'(COPY_BASE) + 5'(k_q) : 5'd0;
   assign bus.o_overflow  = ovf_q;
   assign bus.o_underflow = unf_q;
endmodule
